// File: rtl/game_counter_ctrl.sv
// Multi-mode up/down game counter with win/loss scoring and a RUN/OVER state
// machine. GAMEOVER and WHO hold in OVER until INIT or gameover_ack releases them.
module game_counter_ctrl #(
  parameter int COUNTER_SIZE   = 4,
  parameter int SCORE_SIZE     = 4,
  parameter int GAMEOVER_LIMIT = 15,
  parameter int BIG_STEP       = 2
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [1:0]              ctrl,
  input  logic                    en,
  input  logic                    INIT,
  input  logic [COUNTER_SIZE-1:0] loadValue,
  input  logic                    gameover_ack,
  output logic [COUNTER_SIZE-1:0] count,
  output logic [SCORE_SIZE-1:0]   win_count,
  output logic [SCORE_SIZE-1:0]   loser_count,
  output logic                    WINNER,
  output logic                    LOSER,
  output logic                    GAMEOVER,
  output logic [1:0]              WHO
);

  typedef enum logic {RUN, OVER} state_t;

  localparam logic [COUNTER_SIZE-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_SIZE-1:0] CNT_ONE  = COUNTER_SIZE'(1);
  localparam logic [COUNTER_SIZE-1:0] CNT_STEP = COUNTER_SIZE'(BIG_STEP);
  localparam logic [SCORE_SIZE-1:0]   SC_ONE   = SCORE_SIZE'(1);
  localparam logic [SCORE_SIZE-1:0]   SC_LIMIT = SCORE_SIZE'(GAMEOVER_LIMIT);

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

  state_t                  state;
  logic [COUNTER_SIZE-1:0] next_count;
  logic [SCORE_SIZE-1:0]   win_inc;
  logic [SCORE_SIZE-1:0]   loser_inc;

  // NOTE: a combinational block assigns every output on every path (a default
  // here, via the full case) so no latch is inferred.
  always_comb begin
    next_count = count;
    case (ctrl)
      2'b00:   next_count = count + CNT_ONE;
      2'b01:   next_count = count + CNT_STEP;
      2'b10:   next_count = count - CNT_ONE;
      default: next_count = count - CNT_STEP;
    endcase
  end

  assign win_inc   = win_count + SC_ONE;
  assign loser_inc = loser_count + SC_ONE;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, e.g. the flags see the count before it moves.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state       <= RUN;
      count       <= '0;
      win_count   <= '0;
      loser_count <= '0;
      WINNER      <= 1'b0;
      LOSER       <= 1'b0;
      GAMEOVER    <= 1'b0;
      WHO         <= WHO_NONE;
    end else begin
      WINNER <= 1'b0;
      LOSER  <= 1'b0;
      if (INIT) begin
        // Load/restart wins over everything else in either state.
        state       <= RUN;
        count       <= loadValue;
        win_count   <= '0;
        loser_count <= '0;
        GAMEOVER    <= 1'b0;
        WHO         <= WHO_NONE;
      end else begin
        case (state)
          RUN: begin
            if (en) begin
              count <= next_count;
              if (count == '0) begin
                LOSER       <= 1'b1;
                loser_count <= loser_inc;
                if (loser_inc == SC_LIMIT) begin
                  GAMEOVER <= 1'b1;
                  WHO      <= WHO_LOSER;
                  state    <= OVER;
                end
              end else if (count == CNT_MAX) begin
                WINNER    <= 1'b1;
                win_count <= win_inc;
                if (win_inc == SC_LIMIT) begin
                  GAMEOVER <= 1'b1;
                  WHO      <= WHO_WINNER;
                  state    <= OVER;
                end
              end
            end
          end
          OVER: begin
            // Frozen until acknowledged; ack alone restarts from zero.
            if (gameover_ack) begin
              state       <= RUN;
              count       <= '0;
              win_count   <= '0;
              loser_count <= '0;
              GAMEOVER    <= 1'b0;
              WHO         <= WHO_NONE;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_counter_ctrl.sv
// Bench for game_counter_ctrl: a default-sized instance and a small 2-bit
// instance with a score limit of 2 for the game-over and release sequences.
module tb_game_counter_ctrl;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  // Instance A: COUNTER_SIZE=4, SCORE_SIZE=4, GAMEOVER_LIMIT=15, BIG_STEP=2
  logic [1:0] ctrl_a;
  logic       en_a, init_a, ack_a;
  logic [3:0] load_a, count_a, win_a, loss_a;
  logic       winner_a, loser_a, go_a;
  logic [1:0] who_a;

  // Instance B: COUNTER_SIZE=2, SCORE_SIZE=4, GAMEOVER_LIMIT=2, BIG_STEP=1
  logic [1:0] ctrl_b;
  logic       en_b, init_b, ack_b;
  logic [1:0] load_b, count_b;
  logic [3:0] win_b, loss_b;
  logic       winner_b, loser_b, go_b;
  logic [1:0] who_b;

  game_counter_ctrl #(
    .COUNTER_SIZE(4), .SCORE_SIZE(4), .GAMEOVER_LIMIT(15), .BIG_STEP(2)
  ) dut_a (
    .clk(clk), .rst_l(rst_l), .ctrl(ctrl_a), .en(en_a), .INIT(init_a),
    .loadValue(load_a), .gameover_ack(ack_a), .count(count_a),
    .win_count(win_a), .loser_count(loss_a), .WINNER(winner_a),
    .LOSER(loser_a), .GAMEOVER(go_a), .WHO(who_a)
  );

  game_counter_ctrl #(
    .COUNTER_SIZE(2), .SCORE_SIZE(4), .GAMEOVER_LIMIT(2), .BIG_STEP(1)
  ) dut_b (
    .clk(clk), .rst_l(rst_l), .ctrl(ctrl_b), .en(en_b), .INIT(init_b),
    .loadValue(load_b), .gameover_ack(ack_b), .count(count_b),
    .win_count(win_b), .loser_count(loss_b), .WINNER(winner_b),
    .LOSER(loser_b), .GAMEOVER(go_b), .WHO(who_b)
  );

  typedef struct {
    bit         sel;      // 0 = instance A, 1 = instance B
    bit         init;
    logic [3:0] load;
    logic [1:0] ctrl;
    bit         en;
    bit         ack;
    logic [3:0] e_count;
    logic [3:0] e_win;
    logic [3:0] e_loss;
    bit         e_winner;
    bit         e_loser;
    bit         e_go;
    logic [1:0] e_who;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic void add(input bit sel, input bit init, input int load,
                              input int ctrl, input bit en, input bit ack,
                              input int cnt, input int win, input int loss,
                              input bit wr, input bit ls, input bit go,
                              input int who);
    vec_t v;
    v.sel = sel; v.init = init; v.load = 4'(load); v.ctrl = 2'(ctrl);
    v.en = en; v.ack = ack; v.e_count = 4'(cnt); v.e_win = 4'(win);
    v.e_loss = 4'(loss); v.e_winner = wr; v.e_loser = ls; v.e_go = go;
    v.e_who = 2'(who);
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    init_a = 0; en_a = 0; ack_a = 0; ctrl_a = 2'b00; load_a = '0;
    init_b = 0; en_b = 0; ack_b = 0; ctrl_b = 2'b00; load_b = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a_count"},  int'(count_a),  0);
    check({tag, ".a_win"},    int'(win_a),    0);
    check({tag, ".a_loss"},   int'(loss_a),   0);
    check({tag, ".a_flags"},  int'({winner_a, loser_a, go_a}), 0);
    check({tag, ".a_who"},    int'(who_a),    0);
    check({tag, ".b_count"},  int'(count_b),  0);
    check({tag, ".b_scores"}, int'({win_b, loss_b}), 0);
    check({tag, ".b_flags"},  int'({winner_b, loser_b, go_b}), 0);
    check({tag, ".b_who"},    int'(who_b),    0);
  endtask

  // Drive one vector, queue its expectation, compare one edge later.
  task automatic apply(input int idx, input vec_t v);
    vec_t  e;
    string t;
    @(negedge clk);
    idle_inputs();
    if (!v.sel) begin
      init_a = v.init; load_a = v.load; ctrl_a = v.ctrl; en_a = v.en; ack_a = v.ack;
    end else begin
      init_b = v.init; load_b = v.load[1:0]; ctrl_b = v.ctrl; en_b = v.en; ack_b = v.ack;
    end
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = $sformatf("v%0d%s", idx, e.sel ? "b" : "a");
    if (!e.sel) begin
      check({t, ".count"},    int'(count_a),  int'(e.e_count));
      check({t, ".win"},      int'(win_a),    int'(e.e_win));
      check({t, ".loss"},     int'(loss_a),   int'(e.e_loss));
      check({t, ".WINNER"},   int'(winner_a), int'(e.e_winner));
      check({t, ".LOSER"},    int'(loser_a),  int'(e.e_loser));
      check({t, ".GAMEOVER"}, int'(go_a),     int'(e.e_go));
      check({t, ".WHO"},      int'(who_a),    int'(e.e_who));
    end else begin
      check({t, ".count"},    int'(count_b),  int'(e.e_count));
      check({t, ".win"},      int'(win_b),    int'(e.e_win));
      check({t, ".loss"},     int'(loss_b),   int'(e.e_loss));
      check({t, ".WINNER"},   int'(winner_b), int'(e.e_winner));
      check({t, ".LOSER"},    int'(loser_b),  int'(e.e_loser));
      check({t, ".GAMEOVER"}, int'(go_b),     int'(e.e_go));
      check({t, ".WHO"},      int'(who_b),    int'(e.e_who));
    end
  endtask

  initial begin
    //   sel init load ctrl en ack | cnt win loss WINNER LOSER GO WHO
    // A: up by one across MAX
    add(0, 1, 14, 0, 0, 0,   14, 0, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0, 1, 0,   15, 0, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0, 1, 0,    0, 1, 0, 1, 0, 0, 0);
    add(0, 0,  0, 0, 1, 0,    1, 1, 1, 0, 1, 0, 0);
    // A: INIT with en=1 ignores en; then down by BIG_STEP with wrap
    add(0, 1,  1, 3, 1, 0,    1, 0, 0, 0, 0, 0, 0);
    add(0, 0,  0, 3, 1, 0,   15, 0, 0, 0, 0, 0, 0);
    add(0, 0,  0, 3, 1, 0,   13, 1, 0, 1, 0, 0, 0);
    add(0, 0,  0, 3, 1, 0,   11, 1, 0, 0, 0, 0, 0);
    // A: enable hold through all modes
    add(0, 1,  7, 2, 1, 0,    7, 0, 0, 0, 0, 0, 0);
    for (int m = 0; m < 5; m++)
      add(0, 0, 0, m % 4, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    // A: +BIG_STEP, -1, ack ignored in RUN
    add(0, 0,  0, 1, 1, 0,    9, 0, 0, 0, 0, 0, 0);
    add(0, 0,  0, 2, 1, 0,    8, 0, 0, 0, 0, 0, 0);
    add(0, 0,  0, 0, 0, 1,    8, 0, 0, 0, 0, 0, 0);
    // B: loser-side game over, frozen in OVER, ack release
    add(1, 1,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    1, 0, 1, 0, 1, 0, 0);
    add(1, 0,  0, 0, 1, 0,    2, 0, 1, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    3, 0, 1, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    0, 1, 1, 1, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    1, 1, 2, 0, 1, 1, 1);
    add(1, 0,  0, 0, 1, 0,    1, 1, 2, 0, 0, 1, 1);
    add(1, 0,  0, 3, 1, 0,    1, 1, 2, 0, 0, 1, 1);
    add(1, 0,  0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 0);
    // B: winner-side game over counting down, then INIT beats ack
    add(1, 1,  3, 0, 0, 0,    3, 0, 0, 0, 0, 0, 0);
    add(1, 0,  0, 2, 1, 0,    2, 1, 0, 1, 0, 0, 0);
    add(1, 0,  0, 2, 1, 0,    1, 1, 0, 0, 0, 0, 0);
    add(1, 0,  0, 2, 1, 0,    0, 1, 0, 0, 0, 0, 0);
    add(1, 0,  0, 2, 1, 0,    3, 1, 1, 0, 1, 0, 0);
    add(1, 0,  0, 2, 1, 0,    2, 2, 1, 1, 0, 1, 2);
    add(1, 0,  0, 2, 1, 0,    2, 2, 1, 0, 0, 1, 2);
    add(1, 1,  1, 0, 0, 1,    1, 0, 0, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    2, 0, 0, 0, 0, 0, 0);
    // Set up for the asynchronous reset check: B in OVER, A holding 9
    add(1, 1,  0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    1, 0, 1, 0, 1, 0, 0);
    add(1, 0,  0, 0, 1, 0,    2, 0, 1, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    3, 0, 1, 0, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    0, 1, 1, 1, 0, 0, 0);
    add(1, 0,  0, 0, 1, 0,    1, 1, 2, 0, 1, 1, 1);
    add(0, 1,  9, 0, 0, 0,    9, 0, 0, 0, 0, 0, 0);

    idle_inputs();
    rst_l = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_l = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // Mid-cycle asynchronous reset with A at 9 and B in OVER.
    @(negedge clk);
    idle_inputs();
    check("pre_rst.a_count", int'(count_a), 9);
    check("pre_rst.b_go",    int'(go_b),    1);
    @(posedge clk);
    #3;
    rst_l = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
